multi_cycle_cu: RTL and testbench
=================================

// Module: multi_cycle_cu
// PURPOSE
//  Multi-cycle control unit for the MIPS subset add/sub/subu/slt/sltu/ori/addiu/lw/sw/beq/j.
//  Sequences the shared ALU/memory datapath through IF/ID/EXE/MEM/WB, with wait states on a
//  ready handshake to the single unified memory. Traps illegal instructions and memory timeouts.
//  Sits beside the datapath. Inst comes from the datapath IR, which is stable after IRWr.
// PARAMETERS
//  TIMEOUT  15  max consecutive cycles without mem_ready in IF or MEM before trapping (1..255)
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   asynchronous, active-low reset
//  Inst      in   32  current IR contents; OP=Inst[31:26], Func=Inst[5:0]
//  zero      in   1   ALU zero flag
//  mem_ready in   1   memory has completed the current MemRd/MemWr this cycle
//  PCWr      out  1   unconditional PC write
//  PCWrCond  out  1   PC write if zero (beq)
//  PCSrc     out  2   00 ALU result (PC+4); 01 branch target; 10 jump target
//  IorD      out  1   memory address: 0 = PC, 1 = ALU-out register
//  MemRd     out  1   memory read request
//  MemWr     out  1   memory write request
//  IRWr      out  1   load IR from memory data
//  RegDst    out  1   1 = rd, 0 = rt
//  RegWr     out  1   register file write
//  MemtoReg  out  1   write-back source: 1 = MDR, 0 = ALU-out
//  ExtOp     out  1   1 = sign-extend imm16, 0 = zero-extend
//  ALUSrcA   out  1   0 = PC, 1 = rs
//  ALUSrcB   out  2   00 rt; 01 const 4; 10 ext imm; 11 ext imm<<2
//  ALUctr    out  3   000 addu, 001 add, 010 or, 100 subu, 101 sub, 110 sltu, 111 slt
//  retire    out  1   one-cycle pulse on the last cycle of each completed instruction
//  err       out  1   sticky trap flag; cleared only by reset
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=S_IF, wait_cnt=0, err=0. All outputs are decoded Moore-style
//    from state and Inst. Write strobes (PCWr, PCWrCond, IRWr, RegWr, MemWr) are 0 while rst_n=0.
//  - S_IF: IorD=0, MemRd=1, ALUSrcA=0, ALUSrcB=01, ALUctr=000.
//    When mem_ready=1: IRWr=1, PCWr=1, PCSrc=00, go to S_ID. Otherwise hold in S_IF.
//  - S_ID: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUctr=000 (branch target into ALU-out).
//    j: PCWr=1, PCSrc=10, retire=1, go to S_IF.
//    Any other legal opcode: go to S_EXE. Illegal OP/Func: go to S_ERR.
//  - S_EXE: ALUSrcA=1.
//    R-type: ALUSrcB=00, ALUctr per Func, go to S_WB.
//    ori: ALUSrcB=10, ExtOp=0, ALUctr=010, go to S_WB.
//    addiu: ALUSrcB=10, ExtOp=1, ALUctr=000, go to S_WB.
//    lw/sw: ALUSrcB=10, ExtOp=1, ALUctr=000, go to S_MEM.
//    beq: ALUSrcB=00, ALUctr=100, PCWrCond=1, PCSrc=01, retire=1, go to S_IF.
//  - S_MEM: IorD=1. lw asserts MemRd=1; sw asserts MemWr=1 (held until ready).
//    On mem_ready: lw goes to S_WB; sw raises retire=1 and goes to S_IF.
//  - S_WB: RegWr=1, retire=1, go to S_IF.
//    R-type: RegDst=1, MemtoReg=0. ori/addiu: RegDst=0, MemtoReg=0. lw: RegDst=0, MemtoReg=1.
//  - Latency at zero wait states: j 2, beq 3, R/ori/addiu 4, sw 4, lw 5 cycles.
//    Each cycle of mem_ready=0 in S_IF or S_MEM adds one cycle.
//  - wait_cnt increments on each S_IF/S_MEM cycle with mem_ready=0, saturates at TIMEOUT,
//    and clears on mem_ready=1 or state exit.
//    Reaching TIMEOUT with mem_ready still 0 goes to S_ERR. mem_ready=1 in that same cycle wins.
//  - S_ERR: absorbing state. err=1, all strobes 0, MemRd=MemWr=0. Exit only by reset.
//  - Reset mid-instruction: the in-flight instruction is abandoned. No partial register write
//    occurs after rst_n falls, and fetch restarts in S_IF.
//  - Inst is sampled only in S_ID/S_EXE/S_MEM/S_WB. In S_IF, Inst is don't-care.
// STRUCTURE
//  - cu_pkg: state encoding (S_IF, S_ID, S_EXE, S_MEM, S_WB, S_ERR; 3-bit), OP/Func constants,
//    ALUctr codes, PCSrc/ALUSrcB codes.
//  - Sub-module inst_class_dec (combinational): Inst -> is_r, is_ori, is_addiu, is_lw, is_sw,
//    is_beq, is_j, illegal, r_aluctr[2:0].
//  - Top level: state register, wait_cnt, err, and output decode.
// TESTING
//  1 add $3,$1,$2 (0x00221820), mem_ready=1 -> 4 cycles IF/ID/EXE/WB; RegWr=1, RegDst=1
//    in WB; ALUctr=001 in EXE; one retire pulse.
//  2 lw $2,4($1) (0x8C220004), mem_ready low 3 cycles in MEM -> MemRd held, IorD=1;
//    WB with MemtoReg=1 on cycle 8 of the instruction.
//  3 beq $1,$2,+3 (0x10220003) with zero=1, then zero=0 -> PCWrCond=1, PCSrc=01 in EXE;
//    3 cycles, no RegWr.
//  4 j 0x100 (0x08000100) -> PCWr=1, PCSrc=10 in ID; retire after 2 cycles; next state S_IF.
//  5 Illegal OP 0x3F, or R-type Func 0x00 -> S_ERR, err=1, all strobes 0 for 20 cycles;
//    rst_n pulse -> err=0, S_IF.
//  6 mem_ready stuck 0 in IF -> S_ERR after TIMEOUT=15 cycles.
//    Also assert rst_n=0 during S_WB -> RegWr deasserts immediately.

Source files
------------

// File: rtl/cu_pkg.sv
// Purpose: shared encodings for the multi-cycle MIPS-subset control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cu_pkg;

    // Controller phases; S_ERR is absorbing until reset.
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    // Primary opcodes (Inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (Inst[5:0])
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU operation codes
    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUBU = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // PC source select
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

endpackage

// File: rtl/inst_class_dec.sv
// Purpose: classify the IR opcode/function into instruction classes and R-type ALU op.
// Latency: purely combinational.
// Backpressure: none; consumer samples only when the IR is stable.
module inst_class_dec
    import cu_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output logic       is_r_o,
    output logic       is_ori_o,
    output logic       is_addiu_o,
    output logic       is_lw_o,
    output logic       is_sw_o,
    output logic       is_beq_o,
    output logic       is_j_o,
    output logic       illegal_o,
    output logic [2:0] r_aluctr_o
);

    // Anything outside the supported opcode/function set is flagged illegal.
    always_comb begin
        is_r_o     = 1'b0;
        is_ori_o   = 1'b0;
        is_addiu_o = 1'b0;
        is_lw_o    = 1'b0;
        is_sw_o    = 1'b0;
        is_beq_o   = 1'b0;
        is_j_o     = 1'b0;
        illegal_o  = 1'b0;
        r_aluctr_o = ALU_ADDU;
        case (op_i)
            OP_RTYPE: begin
                is_r_o = 1'b1;
                case (func_i)
                    FN_ADD:  r_aluctr_o = ALU_ADD;
                    FN_SUB:  r_aluctr_o = ALU_SUB;
                    FN_SUBU: r_aluctr_o = ALU_SUBU;
                    FN_SLT:  r_aluctr_o = ALU_SLT;
                    FN_SLTU: r_aluctr_o = ALU_SLTU;
                    default: begin
                        is_r_o    = 1'b0;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            OP_ORI:   is_ori_o   = 1'b1;
            OP_ADDIU: is_addiu_o = 1'b1;
            OP_LW:    is_lw_o    = 1'b1;
            OP_SW:    is_sw_o    = 1'b1;
            OP_BEQ:   is_beq_o   = 1'b1;
            OP_J:     is_j_o     = 1'b1;
            default:  illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_cu.sv
// Purpose: multi-cycle IF/ID/EXE/MEM/WB sequencer for the shared MIPS-subset datapath.
// Latency: j 2, beq 3, R/ori/addiu/sw 4, lw 5 cycles, plus one per memory wait cycle.
// Backpressure: holds in IF/MEM while mem_ready=0; traps to S_ERR after TIMEOUT waits.
module multi_cycle_cu
    import cu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Inst,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWr,
    output logic        PCWrCond,
    output logic [1:0]  PCSrc,
    output logic        IorD,
    output logic        MemRd,
    output logic        MemWr,
    output logic        IRWr,
    output logic        RegDst,
    output logic        RegWr,
    output logic        MemtoReg,
    output logic        ExtOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUctr,
    output logic        retire,
    output logic        err
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;

    logic       is_r, is_ori, is_addiu, is_lw, is_sw, is_beq, is_j, illegal;
    logic [2:0] r_aluctr;

    // Raw decode before the reset gate on write strobes
    logic pcwr_c, pcwrcond_c, memwr_c, irwr_c, regwr_c, retire_c;

    // Branch resolution happens in the datapath via PCWrCond; the CU never reads zero.
    // Only OP and Func carry control information.
    logic unused_bits;
    assign unused_bits = ^{Inst[25:6], zero};

    inst_class_dec u_dec (
        .op_i       (Inst[31:26]),
        .func_i     (Inst[5:0]),
        .is_r_o     (is_r),
        .is_ori_o   (is_ori),
        .is_addiu_o (is_addiu),
        .is_lw_o    (is_lw),
        .is_sw_o    (is_sw),
        .is_beq_o   (is_beq),
        .is_j_o     (is_j),
        .illegal_o  (illegal),
        .r_aluctr_o (r_aluctr)
    );

    // Next state and memory wait counter; mem_ready on the final allowed cycle beats the trap.
    always_comb begin
        state_d = state_q;
        wait_d  = 8'd0;
        case (state_q)
            S_IF: begin
                if (mem_ready) begin
                    state_d = S_ID;
                end else begin
                    wait_d = (wait_q == TO) ? TO : wait_q + 8'd1;
                    if (wait_q == TO) state_d = S_ERR;
                end
            end
            S_ID: begin
                if (illegal)   state_d = S_ERR;
                else if (is_j) state_d = S_IF;
                else           state_d = S_EXE;
            end
            S_EXE: begin
                if (is_beq)              state_d = S_IF;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_lw ? S_WB : S_IF;
                end else begin
                    wait_d = (wait_q == TO) ? TO : wait_q + 8'd1;
                    if (wait_q == TO) state_d = S_ERR;
                end
            end
            S_WB:    state_d = S_IF;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
        if (state_d != state_q) wait_d = 8'd0;
        err_d = err_q | (state_d == S_ERR);
    end

    // Controller state, wait counter and sticky trap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Control decode from current state and IR class
    always_comb begin
        pcwr_c     = 1'b0;
        pcwrcond_c = 1'b0;
        memwr_c    = 1'b0;
        irwr_c     = 1'b0;
        regwr_c    = 1'b0;
        retire_c   = 1'b0;
        PCSrc      = PCSRC_SEQ;
        IorD       = 1'b0;
        MemRd      = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ExtOp      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RT;
        ALUctr     = ALU_ADDU;
        case (state_q)
            S_IF: begin
                MemRd   = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    irwr_c = 1'b1;
                    pcwr_c = 1'b1;
                end
            end
            S_ID: begin
                ALUSrcB = SRCB_IMMSL2;
                ExtOp   = 1'b1;
                if (is_j) begin
                    pcwr_c   = 1'b1;
                    PCSrc    = PCSRC_JMP;
                    retire_c = 1'b1;
                end
            end
            S_EXE: begin
                ALUSrcA = 1'b1;
                if (is_r) begin
                    ALUSrcB = SRCB_RT;
                    ALUctr  = r_aluctr;
                end else if (is_ori) begin
                    ALUSrcB = SRCB_IMM;
                    ALUctr  = ALU_OR;
                end else if (is_addiu || is_lw || is_sw) begin
                    ALUSrcB = SRCB_IMM;
                    ExtOp   = 1'b1;
                end else if (is_beq) begin
                    ALUctr     = ALU_SUBU;
                    pcwrcond_c = 1'b1;
                    PCSrc      = PCSRC_BR;
                    retire_c   = 1'b1;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRd    = is_lw;
                memwr_c  = is_sw;
                retire_c = is_sw & mem_ready;
            end
            S_WB: begin
                regwr_c  = 1'b1;
                retire_c = 1'b1;
                RegDst   = is_r;
                MemtoReg = is_lw;
            end
            default: ;
        endcase
    end

    // Write strobes drop the moment reset asserts, even mid-cycle.
    assign PCWr     = pcwr_c & rst_n;
    assign PCWrCond = pcwrcond_c & rst_n;
    assign MemWr    = memwr_c & rst_n;
    assign IRWr     = irwr_c & rst_n;
    assign RegWr    = regwr_c & rst_n;
    assign retire   = retire_c & rst_n;
    assign err      = err_q;

endmodule

// File: tb/tb_multi_cycle_cu.sv
module tb_multi_cycle_cu;

    typedef enum {P_IF, P_ID, P_EXE, P_MEM, P_WB} ph_t;

    typedef struct packed {
        logic       pcwr;
        logic       pcwrcond;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memrd;
        logic       memwr;
        logic       irwr;
        logic       regdst;
        logic       regwr;
        logic       memtoreg;
        logic       extop;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] ctr;
        logic       retire;
        logic       err;
    } ov_t;

    typedef struct {
        logic [31:0] inst;
        logic        zv;
        int          if_wait;
        int          mem_wait;
        int          exp_cycles;
        int          exp_regwr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Inst;
    logic        zero;
    logic        mem_ready;
    logic        PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegDst, RegWr, MemtoReg;
    logic        ExtOp, ALUSrcA, retire, err;
    logic [1:0]  PCSrc, ALUSrcB;
    logic [2:0]  ALUctr;

    ov_t act;
    ov_t rst_v;
    ov_t err_v;
    int  n_vec = 0;
    int  n_err = 0;

    assign act = {PCWr, PCWrCond, PCSrc, IorD, MemRd, MemWr, IRWr, RegDst, RegWr,
                  MemtoReg, ExtOp, ALUSrcA, ALUSrcB, ALUctr, retire, err};

    always #5 clk = ~clk;

    multi_cycle_cu #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .Inst(Inst), .zero(zero), .mem_ready(mem_ready),
        .PCWr(PCWr), .PCWrCond(PCWrCond), .PCSrc(PCSrc), .IorD(IorD), .MemRd(MemRd),
        .MemWr(MemWr), .IRWr(IRWr), .RegDst(RegDst), .RegWr(RegWr), .MemtoReg(MemtoReg),
        .ExtOp(ExtOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctr(ALUctr),
        .retire(retire), .err(err)
    );

    function automatic logic [2:0] r_op(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b001;
            6'h22:   return 3'b101;
            6'h23:   return 3'b100;
            6'h2A:   return 3'b111;
            default: return 3'b110;
        endcase
    endfunction

    // Expected controls for one cycle of a phase; retire marks the instruction's final cycle.
    function automatic ov_t exp_out(input ph_t ph, input logic [31:0] inst, input logic rdy,
                                    input logic last);
        ov_t e = '0;
        logic [5:0] op = inst[31:26];
        case (ph)
            P_IF: begin
                e.memrd = 1'b1; e.srcb = 2'b01;
                if (rdy) begin e.irwr = 1'b1; e.pcwr = 1'b1; end
            end
            P_ID: begin
                e.srcb = 2'b11; e.extop = 1'b1;
                if (op == 6'h02) begin e.pcwr = 1'b1; e.pcsrc = 2'b10; end
            end
            P_EXE: begin
                e.srca = 1'b1;
                if (op == 6'h00) begin e.srcb = 2'b00; e.ctr = r_op(inst[5:0]); end
                else if (op == 6'h0D) begin e.srcb = 2'b10; e.ctr = 3'b010; end
                else if (op == 6'h04) begin
                    e.ctr = 3'b100; e.pcwrcond = 1'b1; e.pcsrc = 2'b01;
                end else begin e.srcb = 2'b10; e.extop = 1'b1; end
            end
            P_MEM: begin
                e.iord = 1'b1;
                if (op == 6'h23) e.memrd = 1'b1; else e.memwr = 1'b1;
            end
            default: begin
                e.regwr = 1'b1; e.regdst = (op == 6'h00); e.memtoreg = (op == 6'h23);
            end
        endcase
        e.retire = last && ((ph != P_IF && ph != P_MEM) || rdy);
        return e;
    endfunction

    function automatic int base_lat(input logic [31:0] inst);
        case (inst[31:26])
            6'h02:   return 2;
            6'h04:   return 3;
            6'h23:   return 5;
            default: return 4;
        endcase
    endfunction

    task automatic check(input ov_t e, input string tag);
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, act, e);
        end
    endtask

    task automatic check_int(input int got, input int want, input string tag);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Drives one instruction from fetch to retire, comparing every cycle against the phase model.
    task automatic run_instr(input logic [31:0] inst, input logic zv, input int if_wait,
                             input int mem_wait, output int cycles, output int regwr_n);
        ph_t q[$];
        ph_t ph;
        logic [5:0] op = inst[31:26];
        int iw = if_wait;
        int mw = mem_wait;
        logic rdy;
        q = {P_IF, P_ID};
        if (op != 6'h02) q.push_back(P_EXE);
        if (op == 6'h23 || op == 6'h2B) q.push_back(P_MEM);
        if (op == 6'h00 || op == 6'h0D || op == 6'h09 || op == 6'h23) q.push_back(P_WB);
        cycles = 0;
        regwr_n = 0;
        while (q.size() > 0 && cycles < 100) begin
            ph = q[0];
            if (ph == P_IF) begin
                rdy = (iw == 0); Inst = $urandom;
            end else if (ph == P_MEM) begin
                rdy = (mw == 0); Inst = inst;
            end else begin
                rdy = 1'($urandom_range(0, 1)); Inst = inst;
            end
            mem_ready = rdy;
            zero = zv;
            @(negedge clk);
            check(exp_out(ph, inst, rdy, q.size() == 1), ph.name());
            if (act.regwr) regwr_n++;
            cycles++;
            if ((ph == P_IF || ph == P_MEM) && !rdy) begin
                if (ph == P_IF) iw--; else mw--;
            end else begin
                void'(q.pop_front());
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0; mem_ready = 1'b1; Inst = $urandom;
        #1 check(rst_v, tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic illegal_case(input logic [31:0] bad);
        Inst = $urandom; mem_ready = 1'b1; zero = 1'b0;
        @(negedge clk); check(exp_out(P_IF, bad, 1'b1, 1'b0), "ill_if");
        @(posedge clk); #1;
        Inst = bad; mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk); check(exp_out(P_ID, bad, 1'b0, 1'b0), "ill_id");
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            Inst = $urandom; mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk); check(err_v, "err_hold");
            @(posedge clk); #1;
        end
        pulse_reset("err_clear");
    endtask

    function automatic logic [31:0] rand_inst(input int k);
        logic [31:0] r = $urandom;
        case (k)
            0: return {6'h00, r[25:11], 5'd0, 6'h20};
            1: return {6'h00, r[25:11], 5'd0, 6'h22};
            2: return {6'h00, r[25:11], 5'd0, 6'h23};
            3: return {6'h00, r[25:11], 5'd0, 6'h2A};
            4: return {6'h00, r[25:11], 5'd0, 6'h2B};
            5: return {6'h0D, r[25:0]};
            6: return {6'h09, r[25:0]};
            7: return {6'h23, r[25:0]};
            8: return {6'h2B, r[25:0]};
            9: return {6'h04, r[25:0]};
            default: return {6'h02, r[25:0]};
        endcase
    endfunction

    vec_t tbl[14];

    initial begin
        int cyc, rw, iw, mw;
        logic [31:0] ins;

        tbl[0]  = '{32'h00221820, 1'b0, 0, 0, 4, 1};   // add
        tbl[1]  = '{32'h8C220004, 1'b0, 0, 3, 8, 1};   // lw, 3 waits in MEM
        tbl[2]  = '{32'h10220003, 1'b1, 0, 0, 3, 0};   // beq taken
        tbl[3]  = '{32'h10220003, 1'b0, 0, 0, 3, 0};   // beq not taken
        tbl[4]  = '{32'h08000100, 1'b0, 0, 0, 2, 0};   // j
        tbl[5]  = '{32'hAC220004, 1'b0, 0, 0, 4, 0};   // sw
        tbl[6]  = '{32'h3422FFFF, 1'b0, 0, 0, 4, 1};   // ori
        tbl[7]  = '{32'h2422FFFC, 1'b0, 0, 0, 4, 1};   // addiu
        tbl[8]  = '{32'h00221822, 1'b0, 0, 0, 4, 1};   // sub
        tbl[9]  = '{32'h0022182A, 1'b0, 2, 0, 6, 1};   // slt, 2 fetch waits
        tbl[10] = '{32'h0022182B, 1'b0, 0, 0, 4, 1};   // sltu
        tbl[11] = '{32'h00221823, 1'b0, 0, 0, 4, 1};   // subu
        tbl[12] = '{32'h8C220004, 1'b0, 0, 15, 20, 1}; // lw, longest tolerated MEM wait
        tbl[13] = '{32'h00221820, 1'b0, 15, 0, 19, 1}; // add, longest tolerated IF wait

        rst_v = '0; rst_v.memrd = 1'b1; rst_v.srcb = 2'b01;
        err_v = '0; err_v.err = 1'b1;

        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; Inst = 32'h00221820;
        #3 check(rst_v, "reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].inst, tbl[i].zv, tbl[i].if_wait, tbl[i].mem_wait, cyc, rw);
            check_int(cyc, tbl[i].exp_cycles, $sformatf("latency[%0d]", i));
            check_int(rw, tbl[i].exp_regwr, $sformatf("regwr[%0d]", i));
        end

        illegal_case(32'hFC000000);
        illegal_case(32'h00221800);

        // Fetch never completes: sixteen waiting cycles exhaust the budget of fifteen.
        for (int i = 0; i < 16; i++) begin
            Inst = $urandom; mem_ready = 1'b0;
            @(negedge clk); check(exp_out(P_IF, 32'h0, 1'b0, 1'b0), "to_wait");
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk); check(err_v, "to_err");
            @(posedge clk); #1;
        end
        pulse_reset("to_clear");

        // Reset dropped in the write-back cycle of an add must kill RegWr at once.
        ins = 32'h00221820;
        mem_ready = 1'b1; Inst = $urandom;
        @(negedge clk); check(exp_out(P_IF, ins, 1'b1, 1'b0), "wbrst_if");
        @(posedge clk); #1 Inst = ins;
        @(negedge clk); check(exp_out(P_ID, ins, 1'b1, 1'b0), "wbrst_id");
        @(posedge clk); #1;
        @(negedge clk); check(exp_out(P_EXE, ins, 1'b1, 1'b0), "wbrst_exe");
        @(posedge clk); #1;
        @(negedge clk); check(exp_out(P_WB, ins, 1'b1, 1'b1), "wbrst_wb");
        #1 rst_n = 1'b0;
        #1 check(rst_v, "wbrst_regwr");
        @(posedge clk); #1 rst_n = 1'b1;
        run_instr(ins, 1'b0, 0, 0, cyc, rw);
        check_int(cyc, 4, "wbrst_restart");

        // Random legal instruction stream with random memory wait states.
        for (int n = 0; n < 150; n++) begin
            ins = rand_inst($urandom_range(0, 10));
            iw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            mw = (ins[31:26] == 6'h23 || ins[31:26] == 6'h2B) ? $urandom_range(0, 4) : 0;
            run_instr(ins, 1'($urandom_range(0, 1)), iw, mw, cyc, rw);
            check_int(cyc, base_lat(ins) + iw + mw, "rand_latency");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
